// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_fifo
//  Description : Captures core commit activity into a small trace FIFO.
//
//                Each clock edge, the module forms three flags from the
//                core's commit strobes:
//                  - regw : register-file write to a register other than x0
//                  - memw : data-memory store
//                  - memr : data-memory load
//                When tracing is enabled and any flag is set, it stamps one
//                record with the free-running cycle counter and pushes it.
//
//                The consumer sees the head record through a valid/ready
//                handshake. Records that arrive while the FIFO is full, and
//                no pop happens on that edge, are dropped and counted.
//
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                trace_en        - capture enable
//                reg_write_sig, reg_num, reg_data
//                                - register write-back tap
//                wr, rd, addr, wr_data, rd_data
//                                - data-memory tap
//                t_ready / t_valid / t_* fields
//                                - head-record handshake
//                level           - current entry count
//                drop_count      - records lost to overflow (saturating)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     t_ready,
    output logic                     t_valid,
    output logic [2:0]               t_flags,
    output logic [15:0]              t_cycle,
    output logic [4:0]               t_reg_num,
    output logic [DATA_W-1:0]        t_reg_data,
    output logic [8:0]               t_addr,
    output logic [DATA_W-1:0]        t_mem_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_LVL_W-1:0] c_LVL_FULL  = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_LVL_EMPTY = '0;
    localparam logic [c_LVL_W-1:0] c_LVL_ONE   = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [15:0]        c_DROP_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]        r_cycle;
    logic [15:0]        r_drop;
    logic [c_LVL_W-1:0] r_level;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    // Record storage, one array per field. It is never reset: the level
    // and pointers alone decide which entries are meaningful.
    logic [2:0]         r_mem_flags    [DEPTH];
    logic [15:0]        r_mem_cycle    [DEPTH];
    logic [4:0]         r_mem_reg_num  [DEPTH];
    logic [DATA_W-1:0]  r_mem_reg_data [DEPTH];
    logic [8:0]         r_mem_addr     [DEPTH];
    logic [DATA_W-1:0]  r_mem_data     [DEPTH];

    // ------------------------------------------------------------------
    // Capture decode
    // ------------------------------------------------------------------
    logic              w_regw;
    logic [2:0]        w_flags;
    logic              w_event;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Writes to x0 are architecturally invisible, so they are not traced.
    assign w_regw  = reg_write_sig && (reg_num != 5'd0);
    assign w_flags = {rd, wr, w_regw};
    assign w_event = trace_en && (w_flags != 3'b000);

    // A store takes priority on the shared data field. When a load and a
    // store happen together, both flags stay set in the record.
    assign w_mem_data = wr ? wr_data : rd_data;

    assign w_full = (r_level == c_LVL_FULL);

    // Nothing is pushed or popped on a reset edge.
    assign w_pop  = !reset && t_valid && t_ready;

    // When full, a pop on the same edge frees the slot the new record needs.
    assign w_push = !reset && w_event && (!w_full || w_pop);
    assign w_drop = !reset && w_event && w_full && !w_pop;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle  <= 16'd0;
            r_drop   <= 16'd0;
            r_level  <= c_LVL_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // Free-running stamp. It wraps naturally at 16 bits and does
            // not depend on trace_en.
            r_cycle <= r_cycle + 16'd1;

            if (w_drop && (r_drop != c_DROP_MAX)) begin
                r_drop <= r_drop + 16'd1;
            end

            // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Record storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_flags[r_wr_ptr]    <= w_flags;
            r_mem_cycle[r_wr_ptr]    <= r_cycle;
            r_mem_reg_num[r_wr_ptr]  <= reg_num;
            r_mem_reg_data[r_wr_ptr] <= reg_data;
            r_mem_addr[r_wr_ptr]     <= addr;
            r_mem_data[r_wr_ptr]     <= w_mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------
    // The head is read straight from storage. Its fields stay stable while
    // the consumer stalls, because the read pointer only moves on a pop.
    assign t_valid    = (r_level != c_LVL_EMPTY);
    assign t_flags    = r_mem_flags[r_rd_ptr];
    assign t_cycle    = r_mem_cycle[r_rd_ptr];
    assign t_reg_num  = r_mem_reg_num[r_rd_ptr];
    assign t_reg_data = r_mem_reg_data[r_rd_ptr];
    assign t_addr     = r_mem_addr[r_rd_ptr];
    assign t_mem_data = r_mem_data[r_rd_ptr];

    assign level      = r_level;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_trace_fifo
//  Description : Directed self-checking bench for commit_trace_fifo.
//                A queue of expected records is filled whenever a capture
//                event is driven. Entries are checked against the DUT head
//                and popped when the consumer accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_fifo;

    localparam int c_DATA_W = 32;
    localparam int c_DEPTH  = 8;
    localparam int c_LVL_W  = $clog2(c_DEPTH) + 1;

    typedef struct {
        logic [2:0]          flags;
        logic [15:0]         cyc;
        logic [4:0]          rn;
        logic [c_DATA_W-1:0] rdat;
        logic [8:0]          a;
        logic [c_DATA_W-1:0] md;
    } rec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                trace_en;
    logic                reg_write_sig;
    logic [4:0]          reg_num;
    logic [c_DATA_W-1:0] reg_data;
    logic                wr;
    logic                rd;
    logic [8:0]          addr;
    logic [c_DATA_W-1:0] wr_data;
    logic [c_DATA_W-1:0] rd_data;
    logic                t_ready;
    logic                t_valid;
    logic [2:0]          t_flags;
    logic [15:0]         t_cycle;
    logic [4:0]          t_reg_num;
    logic [c_DATA_W-1:0] t_reg_data;
    logic [8:0]          t_addr;
    logic [c_DATA_W-1:0] t_mem_data;
    logic [c_LVL_W-1:0]  level;
    logic [15:0]         drop_count;

    commit_trace_fifo #(
        .DATA_W(c_DATA_W),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trace_en     (trace_en),
        .reg_write_sig(reg_write_sig),
        .reg_num      (reg_num),
        .reg_data     (reg_data),
        .wr           (wr),
        .rd           (rd),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .t_ready      (t_ready),
        .t_valid      (t_valid),
        .t_flags      (t_flags),
        .t_cycle      (t_cycle),
        .t_reg_num    (t_reg_num),
        .t_reg_data   (t_reg_data),
        .t_addr       (t_addr),
        .t_mem_data   (t_mem_data),
        .level        (level),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    // Reference state
    rec_t        q[$];
    logic [15:0] m_cyc;
    logic [15:0] m_drops;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        trace_en      = 1'b1;
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = '0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = 9'd0;
        wr_data       = '0;
        rd_data       = '0;
        t_ready       = 1'b0;
        reset         = 1'b0;
    endtask

    // One clock edge: check the head against the model, predict the edge,
    // let it happen, then check level, valid and drop count.
    task automatic tick();
        logic regw;
        logic ev;
        logic pop;
        rec_t r;
        if (q.size() > 0) begin
            chk("head_valid", 64'(t_valid), 64'(1));
            chk("head_flags", 64'(t_flags), 64'(q[0].flags));
            chk("head_cycle", 64'(t_cycle), 64'(q[0].cyc));
            chk("head_regnum", 64'(t_reg_num), 64'(q[0].rn));
            chk("head_regdata", 64'(t_reg_data), 64'(q[0].rdat));
            chk("head_addr", 64'(t_addr), 64'(q[0].a));
            chk("head_memdata", 64'(t_mem_data), 64'(q[0].md));
        end
        regw = reg_write_sig && (reg_num != 5'd0);
        ev   = trace_en && (regw || wr || rd);
        pop  = (q.size() > 0) && t_ready;
        if (reset) begin
            q.delete();
            m_cyc   = 16'd0;
            m_drops = 16'd0;
        end else begin
            if (pop) void'(q.pop_front());
            if (ev) begin
                r.flags = {rd, wr, regw};
                r.cyc   = m_cyc;
                r.rn    = reg_num;
                r.rdat  = reg_data;
                r.a     = addr;
                r.md    = wr ? wr_data : rd_data;
                if (q.size() < c_DEPTH) q.push_back(r);
                else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end
            m_cyc = m_cyc + 16'd1;
        end
        @(posedge clk);
        #1;
        chk("level", 64'(level), 64'(q.size()));
        chk("t_valid", 64'(t_valid), 64'(q.size() != 0));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * c_DEPTH + 4; i++) begin
            if (q.size() == 0) break;
            idle();
            t_ready = 1'b1;
            tick();
        end
        chk("drained", 64'(level), 64'(0));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        m_cyc   = 16'd0;
        m_drops = 16'd0;
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_valid", 64'(t_valid), 64'(0));
        chk("rst_drop", 64'(drop_count), 64'(0));

        // First edge after release: register write to x5.
        idle();
        reg_write_sig = 1'b1;
        reg_num       = 5'd5;
        reg_data      = 32'hDEADBEEF;
        tick();
        chk("single_valid", 64'(t_valid), 64'(1));
        chk("single_flags", 64'(t_flags), 64'(3'b001));
        chk("single_cycle", 64'(t_cycle), 64'(0));
        chk("single_regnum", 64'(t_reg_num), 64'(5));
        chk("single_level", 64'(level), 64'(1));
        drain();

        // A write to x0 and a store with tracing disabled are both ignored.
        idle();
        reg_write_sig = 1'b1;
        tick();
        idle();
        trace_en = 1'b0;
        wr       = 1'b1;
        tick();
        chk("filter_level", 64'(level), 64'(0));

        // Combined load+store, then a load-only pushed while the first pops.
        idle();
        wr      = 1'b1;
        rd      = 1'b1;
        addr    = 9'h005;
        wr_data = 32'h11;
        rd_data = 32'h22;
        tick();
        chk("ldst_flags", 64'(t_flags), 64'(3'b110));
        chk("ldst_data", 64'(t_mem_data), 64'(32'h11));
        idle();
        rd      = 1'b1;
        rd_data = 32'h22;
        t_ready = 1'b1;
        tick();
        chk("ld_flags", 64'(t_flags), 64'(3'b100));
        chk("ld_data", 64'(t_mem_data), 64'(32'h22));
        chk("ld_level", 64'(level), 64'(1));
        drain();

        // Ready while empty leaves the FIFO empty.
        idle();
        t_ready = 1'b1;
        tick();
        chk("underflow_level", 64'(level), 64'(0));

        // Overflow: ten stores into eight slots.
        for (int i = 0; i < 10; i++) begin
            idle();
            wr      = 1'b1;
            addr    = 9'(9'h010 + i);
            wr_data = 32'(32'hA000 + i);
            tick();
        end
        chk("ovf_level", 64'(level), 64'(8));
        chk("ovf_drop", 64'(drop_count), 64'(2));
        chk("ovf_head", 64'(t_addr), 64'(9'h010));

        // Push and pop on the same edge while full.
        idle();
        wr      = 1'b1;
        addr    = 9'h1AA;
        wr_data = 32'hBEEF;
        t_ready = 1'b1;
        tick();
        chk("fullpp_level", 64'(level), 64'(8));
        chk("fullpp_drop", 64'(drop_count), 64'(2));
        chk("fullpp_head", 64'(t_addr), 64'(9'h011));
        drain();

        // Mixed traffic with a random consumer, exercising pointer wrap.
        for (int i = 0; i < 60; i++) begin
            idle();
            trace_en      = ($urandom_range(0, 7) != 0);
            reg_write_sig = 1'($urandom_range(0, 1));
            reg_num       = 5'($urandom_range(0, 31));
            reg_data      = $urandom;
            wr            = ($urandom_range(0, 3) == 0);
            rd            = ($urandom_range(0, 3) == 0);
            addr          = 9'($urandom_range(0, 511));
            wr_data       = $urandom;
            rd_data       = $urandom;
            t_ready       = ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        // Reset with five records buffered and a nonzero drop count.
        for (int i = 0; i < c_DEPTH + 1; i++) begin
            idle();
            wr   = 1'b1;
            addr = 9'(9'h040 + i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            t_ready = 1'b1;
            tick();
        end
        chk("pre_rst_level", 64'(level), 64'(5));
        idle();
        reset = 1'b1;
        wr    = 1'b1;
        t_ready = 1'b1;
        tick();
        chk("midrst_level", 64'(level), 64'(0));
        chk("midrst_valid", 64'(t_valid), 64'(0));
        chk("midrst_drop", 64'(drop_count), 64'(0));
        idle();
        wr   = 1'b1;
        addr = 9'h0F0;
        tick();
        chk("post_rst_cycle", 64'(t_cycle), 64'(0));
        chk("post_rst_addr", 64'(t_addr), 64'(9'h0F0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
